// File: rtl/m68k_ddr_bus_front_if.sv
// Signal bundle between the 68000 bus front end, the CPU pins and the DDR bridge request port.
// The master view belongs to the front end (it issues bridge requests); slave is the CPU/bridge side.
interface m68k_ddr_bus_front_if;
   logic [23:1] cpu_addr;
   logic        cpu_as_n;
   logic        cpu_uds_n;
   logic        cpu_lds_n;
   logic        cpu_rw;
   logic [15:0] cpu_dout;
   logic [15:0] cpu_din;
   logic        cpu_dtack_n;
   logic        cpu_berr_n;
   logic [31:0] address;
   logic [15:0] wr_data;
   logic [1:0]  wr_byte_mask;
   logic        i_cen;
   logic        i_wren;
   logic        i_valid_p;
   logic [15:0] rd_data;
   logic        wr_ack_p;
   logic        o_valid_p;
   logic        mem_ready;

   modport master (
      input  cpu_addr,
      input  cpu_as_n,
      input  cpu_uds_n,
      input  cpu_lds_n,
      input  cpu_rw,
      input  cpu_dout,
      output cpu_din,
      output cpu_dtack_n,
      output cpu_berr_n,
      output address,
      output wr_data,
      output wr_byte_mask,
      output i_cen,
      output i_wren,
      output i_valid_p,
      input  rd_data,
      input  wr_ack_p,
      input  o_valid_p,
      input  mem_ready
   );

   modport slave (
      output cpu_addr,
      output cpu_as_n,
      output cpu_uds_n,
      output cpu_lds_n,
      output cpu_rw,
      output cpu_dout,
      input  cpu_din,
      input  cpu_dtack_n,
      input  cpu_berr_n,
      input  address,
      input  wr_data,
      input  wr_byte_mask,
      input  i_cen,
      input  i_wren,
      input  i_valid_p,
      output rd_data,
      output wr_ack_p,
      output o_valid_p,
      output mem_ready
   );
endinterface

// File: rtl/m68k_ddr_bus_front.sv
// 68000 asynchronous bus front end: synchronises the strobes, issues one request per in-window
// bus cycle to the DDR bridge and returns DTACK on completion or BERR on watchdog expiry.
module m68k_ddr_bus_front #(
   parameter logic [23:0] DECODE_MASK    = 24'hF00000,
   parameter logic [23:0] DECODE_MATCH   = 24'h100000,
   parameter logic [31:0] DDR_BASE       = 32'h00000000,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input logic                  sys_clock,
   input logic                  sys_resetn,
   m68k_ddr_bus_front_if.master bus
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StReq  = 3'd1;
   localparam logic [2:0] StWait = 3'd2;
   localparam logic [2:0] StAck  = 3'd3;
   localparam logic [2:0] StBerr = 3'd4;

   localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

   // Strobe synchronisers, bit order {as, uds, lds}; idle level is all ones.
   logic [2:0]  strb_meta_q;
   logic [2:0]  strb_s_q;
   logic        as_s;
   logic        uds_s;
   logic        lds_s;

   logic [2:0]  state_q;
   logic [2:0]  state_d;
   logic [15:0] timer_q;
   logic [15:0] timer_d;
   logic [15:0] timer_inc;
   logic        aborted_q;
   logic        aborted_d;
   logic [31:0] address_q;
   logic [31:0] address_d;
   logic [15:0] wr_data_q;
   logic [15:0] wr_data_d;
   logic [1:0]  mask_q;
   logic [1:0]  mask_d;
   logic        wren_q;
   logic        wren_d;
   logic [15:0] din_q;
   logic [15:0] din_d;
   logic        valid_q;
   logic        valid_d;
   logic        cen_q;
   logic        cen_d;
   logic        dtack_n_q;
   logic        dtack_n_d;
   logic        berr_n_q;
   logic        berr_n_d;

   logic        in_window;
   logic        req_hit;
   logic        done;

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         strb_meta_q <= 3'b111;
         strb_s_q    <= 3'b111;
      end else begin
         strb_meta_q <= {bus.cpu_as_n, bus.cpu_uds_n, bus.cpu_lds_n};
         strb_s_q    <= strb_meta_q;
      end
   end

   assign as_s  = strb_s_q[2];
   assign uds_s = strb_s_q[1];
   assign lds_s = strb_s_q[0];

   assign in_window = (({bus.cpu_addr, 1'b0} & DECODE_MASK) == DECODE_MATCH);
   assign req_hit   = !as_s && (!uds_s || !lds_s) && in_window && bus.mem_ready;
   // Only the completion type matching the outstanding request counts.
   assign done      = wren_q ? bus.o_valid_p : bus.wr_ack_p;
   assign timer_inc = timer_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      aborted_d = aborted_q;
      address_d = address_q;
      wr_data_d = wr_data_q;
      mask_d    = mask_q;
      wren_d    = wren_q;
      din_d     = din_q;

      unique case (state_q)
         StIdle: begin
            timer_d   = '0;
            aborted_d = 1'b0;
            if (req_hit) begin
               state_d   = StReq;
               address_d = DDR_BASE + {8'b0, bus.cpu_addr, 1'b0};
               wr_data_d = bus.cpu_dout;
               mask_d    = {~uds_s, ~lds_s};
               wren_d    = bus.cpu_rw;
            end
         end
         StReq: begin
            timer_d = '0;
            state_d = StWait;
            if (as_s) aborted_d = 1'b1;
         end
         StWait: begin
            timer_d = timer_inc;
            if (as_s) aborted_d = 1'b1;
            if (done) begin
               state_d = StAck;
               if (wren_q) din_d = bus.rd_data;
            end else if (timer_inc == TimeoutLimit) begin
               state_d = StBerr;
            end
         end
         StAck, StBerr: begin
            if (as_s || aborted_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A cycle the CPU already abandoned gets neither DTACK nor BERR; it just drains to idle.
      valid_d   = (state_d == StReq);
      cen_d     = !((state_d == StReq) || (state_d == StWait));
      dtack_n_d = !((state_d == StAck) && !aborted_d);
      berr_n_d  = !((state_d == StBerr) && !aborted_d);
   end

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         aborted_q <= 1'b0;
         address_q <= '0;
         wr_data_q <= '0;
         mask_q    <= '0;
         wren_q    <= 1'b1;
         din_q     <= '0;
         valid_q   <= 1'b0;
         cen_q     <= 1'b1;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         aborted_q <= aborted_d;
         address_q <= address_d;
         wr_data_q <= wr_data_d;
         mask_q    <= mask_d;
         wren_q    <= wren_d;
         din_q     <= din_d;
         valid_q   <= valid_d;
         cen_q     <= cen_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
      end
   end

   assign bus.cpu_din      = din_q;
   assign bus.cpu_dtack_n  = dtack_n_q;
   assign bus.cpu_berr_n   = berr_n_q;
   assign bus.address      = address_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.wr_byte_mask = mask_q;
   assign bus.i_cen        = cen_q;
   assign bus.i_wren       = wren_q;
   assign bus.i_valid_p    = valid_q;

endmodule

// File: tb/tb_m68k_ddr_bus_front.sv
// Bench for m68k_ddr_bus_front: vector table of CPU cycles with a request scoreboard,
// plus hand sequences for timeout, mem_ready stall, abort and reset during WAIT.
module tb_m68k_ddr_bus_front;
   localparam int unsigned TIMEOUT = 1023;

   logic sys_clock;
   logic sys_resetn;
   m68k_ddr_bus_front_if bus();

   m68k_ddr_bus_front #(
      .DECODE_MASK   (24'hF00000),
      .DECODE_MATCH  (24'h100000),
      .DDR_BASE      (32'h00000000),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .sys_clock (sys_clock),
      .sys_resetn(sys_resetn),
      .bus       (bus)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
      logic        wren;
   } req_t;

   typedef struct {
      logic        rw;
      logic [23:0] baddr;
      logic        uds_n;
      logic        lds_n;
      logic [15:0] dout;
      logic [15:0] rdata;
      int          delay;
      logic        in_win;
      logic [31:0] exp_addr;
      logic [1:0]  exp_mask;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          valid_cnt = 0;
   req_t        exp_q[$];
   req_t        mon_e;
   logic [15:0] last_din;
   vec_t        vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard: every request pulse must match the oldest expected request.
   always @(negedge sys_clock) begin
      if (sys_resetn && bus.i_valid_p) begin
         valid_cnt++;
         check("req_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("req_addr", bus.address, mon_e.addr);
            check("req_data", 32'(bus.wr_data), 32'(mon_e.data));
            check("req_mask", 32'(bus.wr_byte_mask), 32'(mon_e.mask));
            check("req_wren", 32'(bus.i_wren), 32'(mon_e.wren));
            check("req_cen", 32'(bus.i_cen), 32'd0);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_din"}, 32'(bus.cpu_din), 32'd0);
      check({tag, "_dtack"}, 32'(bus.cpu_dtack_n), 32'd1);
      check({tag, "_berr"}, 32'(bus.cpu_berr_n), 32'd1);
      check({tag, "_addr"}, bus.address, 32'd0);
      check({tag, "_wrdata"}, 32'(bus.wr_data), 32'd0);
      check({tag, "_mask"}, 32'(bus.wr_byte_mask), 32'd0);
      check({tag, "_cen"}, 32'(bus.i_cen), 32'd1);
      check({tag, "_wren"}, 32'(bus.i_wren), 32'd1);
      check({tag, "_valid"}, 32'(bus.i_valid_p), 32'd0);
   endtask

   task automatic release_bus();
      bus.cpu_as_n  = 1'b1;
      bus.cpu_uds_n = 1'b1;
      bus.cpu_lds_n = 1'b1;
   endtask

   // Starts a CPU cycle on the current negedge and records the request it should produce.
   task automatic start_cycle(input vec_t v);
      req_t e;
      bus.cpu_addr = v.baddr[23:1];
      bus.cpu_rw   = v.rw;
      bus.cpu_dout = v.dout;
      if (v.in_win) begin
         e.addr = v.exp_addr;
         e.data = v.dout;
         e.mask = v.exp_mask;
         e.wren = v.rw;
         exp_q.push_back(e);
      end
      bus.cpu_as_n  = 1'b0;
      bus.cpu_uds_n = v.uds_n;
      bus.cpu_lds_n = v.lds_n;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      do begin
         @(negedge sys_clock);
         n++;
      end while (!bus.i_valid_p && n < limit);
   endtask

   // sel 0 watches cpu_dtack_n, sel 1 watches cpu_berr_n; n == limit means the bound expired.
   task automatic wait_out(input int sel, input logic lvl, input int limit, output int n);
      n = 0;
      do begin
         @(negedge sys_clock);
         n++;
      end while (((sel == 0) ? bus.cpu_dtack_n : bus.cpu_berr_n) !== lvl && n < limit);
   endtask

   task automatic pulse(input logic is_read, input logic [15:0] rdata);
      if (is_read) begin
         bus.o_valid_p = 1'b1;
         bus.rd_data   = rdata;
      end else begin
         bus.wr_ack_p = 1'b1;
      end
      @(negedge sys_clock);
      bus.o_valid_p = 1'b0;
      bus.wr_ack_p  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int base;
      base = valid_cnt;
      @(negedge sys_clock);
      start_cycle(v);
      if (v.in_win) begin
         wait_valid(10, n);
         check("req_latency", n, 3);
         repeat (v.delay) @(negedge sys_clock);
         if (v.delay >= 2) begin
            pulse(!v.rw, 16'hDEAD);
            check("wrong_pulse_dtack", 32'(bus.cpu_dtack_n), 32'd1);
         end
         check("dtack_before", 32'(bus.cpu_dtack_n), 32'd1);
         pulse(v.rw, v.rdata);
         check("dtack_low", 32'(bus.cpu_dtack_n), 32'd0);
         check("berr_idle", 32'(bus.cpu_berr_n), 32'd1);
         if (v.rw) last_din = v.rdata;
         check("cpu_din", 32'(bus.cpu_din), 32'(last_din));
         release_bus();
         wait_out(0, 1'b1, 10, n);
         check("dtack_release", n, 3);
      end else begin
         repeat (20) @(negedge sys_clock);
         check("nowin_dtack", 32'(bus.cpu_dtack_n), 32'd1);
         check("nowin_berr", 32'(bus.cpu_berr_n), 32'd1);
         release_bus();
         repeat (4) @(negedge sys_clock);
      end
      repeat (2) @(negedge sys_clock);
      check("req_count", 32'(valid_cnt - base), 32'(v.in_win));
   endtask

   initial begin
      int   n;
      int   base;
      logic bad;
      vec_t v;

      bus.cpu_addr  = '0;
      bus.cpu_rw    = 1'b1;
      bus.cpu_dout  = '0;
      bus.rd_data   = '0;
      bus.wr_ack_p  = 1'b0;
      bus.o_valid_p = 1'b0;
      bus.mem_ready = 1'b1;
      release_bus();
      last_din   = '0;
      sys_resetn = 1'b0;

      //          rw    baddr        uds   lds   dout      rdata    dly win   exp_addr       mask
      vecs[0] = '{1'b0, 24'h123456, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 20, 1'b1, 32'h00123456, 2'b11};
      vecs[1] = '{1'b1, 24'h100002, 1'b1, 1'b0, 16'h0000, 16'h00A5, 5,  1'b1, 32'h00100002, 2'b01};
      vecs[2] = '{1'b0, 24'h1FFFFE, 1'b0, 1'b1, 16'h1234, 16'h0000, 1,  1'b1, 32'h001FFFFE, 2'b10};
      vecs[3] = '{1'b1, 24'h100000, 1'b0, 1'b0, 16'h5555, 16'hCAFE, 1,  1'b1, 32'h00100000, 2'b11};
      vecs[4] = '{1'b1, 24'h200000, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 32'h0,        2'b00};
      vecs[5] = '{1'b0, 24'h0FFFFE, 1'b0, 1'b0, 16'h4321, 16'h0000, 0,  1'b0, 32'h0,        2'b00};
      vecs[6] = '{1'b1, 24'h1ABCDE, 1'b0, 1'b1, 16'h0000, 16'h5A00, 3,  1'b1, 32'h001ABCDE, 2'b10};
      vecs[7] = '{1'b0, 24'h1FFFF0, 1'b1, 1'b1, 16'h9999, 16'h0000, 0,  1'b0, 32'h0,        2'b00};

      repeat (3) @(negedge sys_clock);
      check_reset_outputs("reset");
      sys_resetn = 1'b1;
      repeat (2) @(negedge sys_clock);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Out-of-window access held for 2000 cycles.
      base = valid_cnt;
      bad  = 1'b0;
      v    = vecs[4];
      @(negedge sys_clock);
      start_cycle(v);
      for (int i = 0; i < 2000; i++) begin
         @(negedge sys_clock);
         if (!bus.cpu_dtack_n || !bus.cpu_berr_n || bus.i_valid_p) bad = 1'b1;
      end
      check("nowin_2000_quiet", 32'(bad), 32'd0);
      check("nowin_2000_noreq", 32'(valid_cnt - base), 32'd0);
      release_bus();
      repeat (4) @(negedge sys_clock);

      // Watchdog: REQ cycle plus TIMEOUT wait cycles, then BERR.
      v = '{1'b0, 24'h100010, 1'b0, 1'b0, 16'h0F0F, 16'h0000, 0, 1'b1, 32'h00100010, 2'b11};
      @(negedge sys_clock);
      start_cycle(v);
      wait_valid(10, n);
      wait_out(1, 1'b0, TIMEOUT + 100, n);
      check("berr_latency", n, TIMEOUT + 1);
      check("berr_no_dtack", 32'(bus.cpu_dtack_n), 32'd1);
      release_bus();
      wait_out(1, 1'b1, 10, n);
      check("berr_release", n, 3);
      pulse(1'b0, 16'h0);
      repeat (5) @(negedge sys_clock);
      check("late_ack_ignored", 32'(bus.cpu_dtack_n), 32'd1);
      run_vec(vecs[2]);

      // Completion in the very cycle the watchdog expires wins.
      v = '{1'b0, 24'h100014, 1'b0, 1'b0, 16'hA1A1, 16'h0000, 0, 1'b1, 32'h00100014, 2'b11};
      @(negedge sys_clock);
      start_cycle(v);
      wait_valid(10, n);
      repeat (TIMEOUT) @(negedge sys_clock);
      pulse(1'b0, 16'h0);
      check("edge_pulse_dtack", 32'(bus.cpu_dtack_n), 32'd0);
      check("edge_pulse_berr", 32'(bus.cpu_berr_n), 32'd1);
      release_bus();
      wait_out(0, 1'b1, 10, n);
      check("edge_pulse_release", n, 3);

      // mem_ready low stalls the request; raising it launches within one cycle.
      base = valid_cnt;
      bus.mem_ready = 1'b0;
      v = '{1'b0, 24'h100100, 1'b0, 1'b0, 16'h7E7E, 16'h0000, 0, 1'b1, 32'h00100100, 2'b11};
      @(negedge sys_clock);
      start_cycle(v);
      repeat (20) @(negedge sys_clock);
      check("not_ready_noreq", 32'(valid_cnt - base), 32'd0);
      bus.mem_ready = 1'b1;
      wait_valid(5, n);
      check("ready_latency", n, 1);
      repeat (3) @(negedge sys_clock);
      pulse(1'b0, 16'h0);
      check("ready_dtack", 32'(bus.cpu_dtack_n), 32'd0);
      release_bus();
      repeat (5) @(negedge sys_clock);

      // Aborted cycle: AS rises during WAIT, completion must not raise DTACK.
      v = '{1'b0, 24'h100200, 1'b0, 1'b0, 16'h3C3C, 16'h0000, 0, 1'b1, 32'h00100200, 2'b11};
      @(negedge sys_clock);
      start_cycle(v);
      wait_valid(10, n);
      release_bus();
      repeat (3) @(negedge sys_clock);
      bad = 1'b0;
      bus.wr_ack_p = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clock);
         bus.wr_ack_p = 1'b0;
         if (!bus.cpu_dtack_n || !bus.cpu_berr_n) bad = 1'b1;
      end
      check("abort_no_dtack", 32'(bad), 32'd0);
      run_vec(vecs[1]);

      // Asynchronous reset while a read is in WAIT.
      v = '{1'b1, 24'h100020, 1'b0, 1'b0, 16'h1111, 16'h0000, 0, 1'b1, 32'h00100020, 2'b11};
      @(negedge sys_clock);
      start_cycle(v);
      wait_valid(10, n);
      repeat (5) @(negedge sys_clock);
      #2 sys_resetn = 1'b0;
      #1 check_reset_outputs("async_reset");
      release_bus();
      repeat (2) @(negedge sys_clock);
      sys_resetn = 1'b1;
      last_din   = '0;
      @(negedge sys_clock);
      pulse(1'b1, 16'h7777);
      repeat (5) @(negedge sys_clock);
      check("stray_valid_dtack", 32'(bus.cpu_dtack_n), 32'd1);
      check("stray_valid_din", 32'(bus.cpu_din), 32'd0);
      run_vec(vecs[0]);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
